seg7_seq_checker: RTL and testbench
===================================

Name: seg7_seq_checker

Overview:
- Receive side of the 7-segment roll-number display path: samples active-low HEX segment codes, decodes each to a digit and tracks the cyclic sequence 5-7-9-8-3 in either direction.
- Reports lock status, sequence errors and completed laps.
- Sits beside the display driver as an on-board self-check, or as the bench-side monitor that consumes the HEX0 bus.

Parameters:
- LOCK_LEN, 3: consecutive correct transitions required to enter LOCKED (legal range 1..15).
- CNT_W, 8: width of lap_count.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears all state on the next posedge.
- hex_in  input  7  segment code, active-low, bit order {g,f,e,d,c,b,a}; sampled only when sample_valid=1.
- sample_valid  input  1  a new code is present this cycle.
- dir  input  1  1 = forward order (5→7→9→8→3→5), 0 = reverse; sampled together with hex_in.
- digit  output  4  last decoded digit 0..9; 4'hF for an unrecognised code.
- digit_valid  output  1  one-cycle pulse, one cycle after an accepted sample.
- code_err  output  1  one-cycle pulse: the sampled code is not a legal 0..9 pattern.
- locked  output  1  level: sequence tracker is in LOCKED.
- seq_err  output  1  one-cycle pulse: a sample broke the sequence while LOCKED.
- lap_count  output  CNT_W  completed laps while LOCKED; saturating.

Behaviour:
- Reset values: digit=4'hF; digit_valid, code_err, locked and seq_err all 0; lap_count=0; internal have_prev=0, streak=0, pos=0, state HUNT.
- Reset dominates sample_valid in the same cycle. Reset mid-lock drops lock immediately.
- Latency: every output reflects a sample exactly one cycle after sample_valid. With no sample_valid, pulse outputs are 0 and everything else holds.
- Decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other pattern: digit=F, code_err=1.
- Sequence positions: P0=5, P1=7, P2=9, P3=8, P4=3. A digit outside this set (including F) is "off-sequence".
- Expected next position from prev and the current sample's dir:
  - dir=1: (prev+1) mod 5.
  - dir=0: (prev+4) mod 5.
  - A direction change therefore takes effect on the sample that carries it.
- A sample with the same digit as the previous sample is a mismatch; there is no hold filtering.
- State HUNT:
  - Off-sequence sample: have_prev=0, streak=0.
  - In-set sample with have_prev=1 and pos==expected: streak+1. If streak reaches LOCK_LEN, go to LOCKED and assert locked on the same output cycle.
  - In-set sample otherwise: streak=0.
  - In every in-set case: pos=new position, have_prev=1.
  - seq_err is never asserted in HUNT.
- State LOCKED:
  - Sample matches expected: stay LOCKED, update pos.
  - Lap: forward transition P4→P0 (dir=1) or reverse transition P0→P4 (dir=0). lap_count+1, saturating at all-ones.
  - Any mismatch (wrong digit, repeat, off-sequence, code_err): seq_err=1, locked=0, go to HUNT, streak=0.
    - Off-sequence sample: have_prev=0.
    - In-set sample: pos=new position, have_prev=1. The mismatching sample seeds the new hunt.
- lap_count clears only on reset; it holds across loss of lock.
- code_err and seq_err may pulse in the same cycle.

Decomposition:
- Shared package seg7_pkg:
  - Active-low segment constants SEG_0..SEG_9.
  - Position constants P0..P4, and DIGIT_BAD=4'hF.
  - Function pos_of_digit (returns valid flag and position).
  - The display driver reuses the same constants.
- One sub-module, seg7_decode: purely combinational, hex_in → {digit, code_err}.
- seg7_seq_checker holds the registers, the HUNT/LOCKED FSM and the counters.

Test Plan:
- Lock and decode: reset, then sample_valid with dir=1 on 0010010, 1111000, 0010000, 0000000.
  - digit outputs are 5, 7, 9, 8, one cycle after each sample.
  - locked rises one cycle after the fourth sample.
  - seq_err stays 0.
- Forward lap: continue the locked forward stream with 0110000 (3) then 0010010 (5).
  - lap_count goes 0→1 one cycle after the 5 sample.
  - locked stays 1.
- Reverse lock and reverse lap: after reset, dir=0, feed 5, 3, 8, 9.
  - locked=1 after the 9 sample.
  - Then feed 7, 5, 3: lap_count=1 one cycle after the 3 sample.
- Mismatch while locked: forward-locked at 9, feed 7 (0000000 expected).
  - seq_err pulses for one cycle; locked=0.
  - Then feed 9, 8, 3: locked=1 again, because 7 seeded the hunt and 7→9→8→3 gives 3 transitions.
- Illegal code: feed 1111111 while locked.
  - digit=F, code_err=1, seq_err=1 in the same cycle; locked=0.
  - The following 5,7,9,8 is needed to relock.
- Reset mid-operation: assert reset while locked with lap_count=2 and sample_valid=1 in the same cycle.
  - Next cycle: locked=0, lap_count=0, digit=F, no pulses.

Source files
------------

// File: rtl/seg7_pkg.sv
// Purpose : shared constants and helpers for the 7-segment roll-number display path.
// Latency : n/a (package only).
// Backpressure: n/a. Segment codes are active-low {g,f,e,d,c,b,a}, also used by the display driver.
package seg7_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [3:0] DIGIT_BAD = 4'hF;

  // Positions of the roll-number digits 5-7-9-8-3 in the cyclic sequence
  localparam logic [2:0] P0 = 3'd0;  // 5
  localparam logic [2:0] P1 = 3'd1;  // 7
  localparam logic [2:0] P2 = 3'd2;  // 9
  localparam logic [2:0] P3 = 3'd3;  // 8
  localparam logic [2:0] P4 = 3'd4;  // 3

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} seq_state_t;

  typedef struct packed {
    logic       vld;  // digit is one of the five sequence digits
    logic [2:0] pos;
  } seq_pos_t;

  function automatic seq_pos_t pos_of_digit(input logic [3:0] d);
    seq_pos_t r;
    r.vld = 1'b1;
    r.pos = P0;
    case (d)
      4'd5:    r.pos = P0;
      4'd7:    r.pos = P1;
      4'd9:    r.pos = P2;
      4'd8:    r.pos = P3;
      4'd3:    r.pos = P4;
      default: r.vld = 1'b0;
    endcase
    return r;
  endfunction

  // Successor of p in the chosen direction, modulo 5
  function automatic logic [2:0] next_pos(input logic [2:0] p, input logic fwd);
    if (fwd) return (p == P4) ? P0 : p + 3'd1;
    else     return (p == P0) ? P4 : p - 3'd1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Purpose : combinational active-low segment code -> digit decoder.
// Latency : 0 cycles (pure combinational).
// Backpressure: none. Ports: hex_in[6:0] in; digit[3:0] (F if unknown), code_err out.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] hex_in,
  output logic [3:0] digit,
  output logic       code_err
);

  always_comb begin
    digit    = DIGIT_BAD;
    code_err = 1'b0;
    case (hex_in)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: code_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_seq_checker.sv
// Purpose : decodes sampled HEX codes and tracks the cyclic 5-7-9-8-3 sequence (either direction).
// Latency : all outputs registered, one cycle after sample_valid.
// Backpressure: none, every valid sample is consumed. Ports: clk, reset, hex_in, sample_valid, dir in;
//           digit, digit_valid, code_err, locked, seq_err, lap_count out.
module seg7_seq_checker
  import seg7_pkg::*;
#(
  parameter int unsigned LOCK_LEN = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       hex_in,
  input  logic             sample_valid,
  input  logic             dir,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             code_err,
  output logic             locked,
  output logic             seq_err,
  output logic [CNT_W-1:0] lap_count
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_LEN);

  logic [3:0] dec_digit;
  logic       dec_err;

  seg7_decode u_decode (
    .hex_in   (hex_in),
    .digit    (dec_digit),
    .code_err (dec_err)
  );

  seq_state_t state;
  logic       have_prev;
  logic [2:0] pos;
  logic [3:0] streak;

  seq_pos_t   cur;
  logic       match;
  logic       is_lap;
  logic [3:0] streak_inc;

  always_comb begin
    cur        = pos_of_digit(dec_digit);
    // A repeated digit never equals next_pos, so it falls out as a mismatch
    match      = have_prev && cur.vld && (cur.pos == next_pos(pos, dir));
    is_lap     = dir ? (pos == P4) : (pos == P0);
    streak_inc = streak + 4'd1;
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      have_prev   <= 1'b0;
      pos         <= P0;
      streak      <= 4'd0;
      digit       <= DIGIT_BAD;
      digit_valid <= 1'b0;
      code_err    <= 1'b0;
      seq_err     <= 1'b0;
      lap_count   <= '0;
    end else begin
      digit_valid <= 1'b0;
      code_err    <= 1'b0;
      seq_err     <= 1'b0;
      if (sample_valid) begin
        digit_valid <= 1'b1;
        digit       <= dec_digit;
        code_err    <= dec_err;
        case (state)
          HUNT: begin
            if (!cur.vld) begin
              have_prev <= 1'b0;
              streak    <= 4'd0;
            end else begin
              pos       <= cur.pos;
              have_prev <= 1'b1;
              if (match) begin
                streak <= streak_inc;
                if (streak_inc == LOCK_TGT) state <= LOCKED;
              end else begin
                streak <= 4'd0;
              end
            end
          end
          LOCKED: begin
            if (match) begin
              pos <= cur.pos;
              if (is_lap && (lap_count != {CNT_W{1'b1}})) lap_count <= lap_count + 1'b1;
            end else begin
              // The breaking sample seeds the next hunt when it is a sequence digit
              seq_err   <= 1'b1;
              state     <= HUNT;
              streak    <= 4'd0;
              have_prev <= cur.vld;
              if (cur.vld) pos <= cur.pos;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_seq_checker.sv
// Purpose : self-checking bench for seg7_seq_checker, directed sequences plus random stream vs a reference model.
// Latency : checks every output 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_seg7_seq_checker;

  localparam int LOCK_LEN = 3;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       hex_in;
  logic             sample_valid;
  logic             dir;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             code_err;
  logic             locked;
  logic             seq_err;
  logic [CNT_W-1:0] lap_count;

  seg7_seq_checker #(.LOCK_LEN(LOCK_LEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .hex_in       (hex_in),
    .sample_valid (sample_valid),
    .dir          (dir),
    .digit        (digit),
    .digit_valid  (digit_valid),
    .code_err     (code_err),
    .locked       (locked),
    .seq_err      (seq_err),
    .lap_count    (lap_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference tables straight from the digit list
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int         ring    [5]  = '{5, 7, 9, 8, 3};

  function automatic int decode_ref(input logic [6:0] h);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == h) return i;
    return 15;
  endfunction

  function automatic int ring_idx(input int d);
    for (int i = 0; i < 5; i++) if (ring[i] == d) return i;
    return -1;
  endfunction

  // Model state
  int m_digit, m_dv, m_cerr, m_lock, m_serr, m_laps;
  int m_prev, m_streak;
  bit m_have;

  task automatic model_reset();
    m_digit = 15; m_dv = 0; m_cerr = 0; m_lock = 0; m_serr = 0; m_laps = 0;
    m_prev = 0; m_streak = 0; m_have = 0;
  endtask

  task automatic model_sample(input logic [6:0] h, input logic d);
    int p, want;
    bit ok, lap;
    m_digit = decode_ref(h);
    m_dv    = 1;
    m_cerr  = (m_digit == 15);
    m_serr  = 0;
    p       = ring_idx(m_digit);
    want    = d ? (m_prev + 1) % 5 : (m_prev + 4) % 5;
    ok      = m_have && (p >= 0) && (p == want);
    if (m_lock == 0) begin
      if (p < 0) begin
        m_have = 0; m_streak = 0;
      end else begin
        if (ok) begin
          m_streak++;
          if (m_streak == LOCK_LEN) m_lock = 1;
        end else m_streak = 0;
        m_prev = p; m_have = 1;
      end
    end else if (ok) begin
      lap = (d && m_prev == 4) || (!d && m_prev == 0);
      if (lap && m_laps < (1 << CNT_W) - 1) m_laps++;
      m_prev = p;
    end else begin
      m_serr = 1; m_lock = 0; m_streak = 0;
      if (p < 0) m_have = 0;
      else begin m_prev = p; m_have = 1; end
    end
  endtask

  // One clock: drive inputs, advance the model, compare every output
  task automatic step(input logic r, input logic sv, input logic [6:0] h, input logic d);
    reset = r; sample_valid = sv; hex_in = h; dir = d;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else if (sv) model_sample(h, d);
    else begin m_dv = 0; m_cerr = 0; m_serr = 0; end
    chk("digit",       int'(digit),       m_digit);
    chk("digit_valid", int'(digit_valid), m_dv);
    chk("code_err",    int'(code_err),    m_cerr);
    chk("locked",      int'(locked),      m_lock);
    chk("seq_err",     int'(seq_err),     m_serr);
    chk("lap_count",   int'(lap_count),   m_laps);
  endtask

  task automatic feed(input int dg, input logic d);
    step(1'b0, 1'b1, seg_tab[dg], d);
  endtask

  int nxt;
  logic rd;
  logic [6:0] rh;

  initial begin
    reset = 1'b1; sample_valid = 1'b0; hex_in = 7'h7F; dir = 1'b1;
    model_reset();

    // Reset state
    step(1'b1, 1'b0, 7'h7F, 1'b1);
    step(1'b1, 1'b1, seg_tab[5], 1'b1);
    chk("rst_digit", int'(digit), 15);
    step(1'b0, 1'b0, 7'h7F, 1'b1);

    // Forward lock on 5,7,9,8
    feed(5, 1'b1); chk("plan_d5", int'(digit), 5);
    feed(7, 1'b1); chk("plan_d7", int'(digit), 7);
    feed(9, 1'b1); chk("plan_lock_early", int'(locked), 0);
    feed(8, 1'b1); chk("plan_lock_fwd", int'(locked), 1);
    // Forward lap
    feed(3, 1'b1); chk("plan_lap0", int'(lap_count), 0);
    feed(5, 1'b1); chk("plan_lap_fwd", int'(lap_count), 1);
    step(1'b0, 1'b0, 7'h00, 1'b1); chk("idle_dv", int'(digit_valid), 0);

    // Reverse lock and lap
    step(1'b1, 1'b0, 7'h7F, 1'b0);
    feed(5, 1'b0); feed(3, 1'b0); feed(8, 1'b0); feed(9, 1'b0);
    chk("plan_lock_rev", int'(locked), 1);
    feed(7, 1'b0); feed(5, 1'b0); feed(3, 1'b0);
    chk("plan_lap_rev", int'(lap_count), 1);

    // Mismatch while locked, then reseeded relock
    step(1'b1, 1'b0, 7'h7F, 1'b1);
    feed(3, 1'b1); feed(5, 1'b1); feed(7, 1'b1); feed(9, 1'b1);
    chk("plan_lock9", int'(locked), 1);
    feed(7, 1'b1);
    chk("plan_serr", int'(seq_err), 1);
    step(1'b0, 1'b0, 7'h7F, 1'b1); chk("plan_serr_pulse", int'(seq_err), 0);
    feed(9, 1'b1); feed(8, 1'b1); feed(3, 1'b1);
    chk("plan_relock", int'(locked), 1);

    // Repeat digit breaks lock
    feed(3, 1'b1); chk("plan_repeat", int'(seq_err), 1);

    // Illegal code while locked
    feed(5, 1'b1); feed(7, 1'b1); feed(9, 1'b1);
    chk("plan_lock_b", int'(locked), 1);
    step(1'b0, 1'b1, 7'b1111111, 1'b1);
    chk("plan_bad_digit", int'(digit), 15);
    chk("plan_bad_cerr", int'(code_err), 1);
    chk("plan_bad_serr", int'(seq_err), 1);
    feed(5, 1'b1); feed(7, 1'b1); feed(9, 1'b1);
    chk("plan_nolock", int'(locked), 0);
    feed(8, 1'b1); chk("plan_relock2", int'(locked), 1);

    // Two laps, then reset together with a sample
    feed(3, 1'b1); feed(5, 1'b1); feed(7, 1'b1); feed(9, 1'b1); feed(8, 1'b1); feed(3, 1'b1); feed(5, 1'b1);
    chk("plan_lap2", int'(lap_count), 2);
    step(1'b1, 1'b1, seg_tab[7], 1'b1);
    chk("plan_rst_lock", int'(locked), 0);
    chk("plan_rst_lap", int'(lap_count), 0);
    chk("plan_rst_dv", int'(digit_valid), 0);

    // Random stream: mostly in-sequence, with direction flips, glitches, gaps and rare resets
    step(1'b0, 1'b0, 7'h7F, 1'b1);
    nxt = 0; rd = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(99) < 4) rd = ~rd;
      if ($urandom_range(999) < 2) begin
        step(1'b1, 1'($urandom_range(1)), seg_tab[5], rd);
      end else if ($urandom_range(99) < 20) begin
        step(1'b0, 1'b0, 7'($urandom), rd);
      end else begin
        case ($urandom_range(99)) inside
          [0:2]:   rh = 7'($urandom);
          [3:6]:   rh = seg_tab[$urandom_range(9)];
          default: rh = seg_tab[ring[nxt]];
        endcase
        step(1'b0, 1'b1, rh, rd);
        if (ring_idx(decode_ref(rh)) >= 0) nxt = ring_idx(decode_ref(rh));
        nxt = rd ? (nxt + 1) % 5 : (nxt + 4) % 5;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
